// File: rtl/st7735_rect_fill_pkg.sv
// st7735_rect_fill_pkg
//   Shared definitions for the ST7735 rectangle-fill sequencer: default panel
//   geometry, default busy timeout, the fill FSM state encoding and an RGB565
//   packing helper used by pattern/demo logic and benches.
package st7735_rect_fill_pkg;

  localparam int DEF_WIDTH        = 160;
  localparam int DEF_HEIGHT       = 120;
  localparam int DEF_BUSY_TIMEOUT = 4095;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FINISH
  } fill_state_t;

  // RGB565 layout is {r[4:0], g[5:0], b[4:0]}.
  function automatic logic [15:0] rgb565_pack(input logic [4:0] r,
                                              input logic [5:0] g,
                                              input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/st7735_busy_timer.sv
// st7735_busy_timer
//   Watchdog for the driver busy handshake. Counts enabled cycles since the
//   last clear and raises expired once BUSY_TIMEOUT cycles have been spent.
// Ports
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   clear    in  restart the count (asserted on every FSM state change)
//   enable   in  count this cycle (waiting states only)
//   expired  out timeout reached; only meaningful while enable is high
module st7735_busy_timer #(
  parameter  int BUSY_TIMEOUT = 4095,
  localparam int TW           = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] count;

  // The count holds the number of cycles already completed in the state, so
  // comparing against BUSY_TIMEOUT-1 ends the wait after exactly BUSY_TIMEOUT cycles.
  assign expired = enable && (count == TW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/st7735_rect_fill.sv
// st7735_rect_fill
//   Accepts one filled-rectangle command, walks it in raster order and issues
//   one pixel write per coordinate, pacing on the driver busy handshake.
// Ports
//   system_clk, reset_n        clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (accept on valid && ready)
//   cmd_x0, cmd_x1             column corners, any order
//   cmd_y0, cmd_y1             row corners, any order
//   cmd_color                  RGB565 fill colour
//   cmd_abort                  stop after the current pixel completes
//   lcd_ready                  driver initialisation finished
//   pix_busy                   driver busy with a pixel
//   pix_write_en               pixel write request
//   pix_x, pix_y, pix_color    current pixel coordinate and colour
//   done                       1-cycle pulse: rectangle finished or aborted
//   error                      1-cycle pulse: command rejected or busy timeout
module st7735_rect_fill
  import st7735_rect_fill_pkg::*;
#(
  parameter  int WIDTH        = DEF_WIDTH,
  parameter  int HEIGHT       = DEF_HEIGHT,
  parameter  int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int XW           = $clog2(WIDTH) + 1,
  localparam int YW           = $clog2(HEIGHT) + 1
) (
  input  logic          system_clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x0,
  input  logic [XW-1:0] cmd_x1,
  input  logic [YW-1:0] cmd_y0,
  input  logic [YW-1:0] cmd_y1,
  input  logic [15:0]   cmd_color,
  input  logic          cmd_abort,
  input  logic          lcd_ready,
  input  logic          pix_busy,
  output logic          pix_write_en,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [15:0]   pix_color,
  output logic          done,
  output logic          error
);

  fill_state_t   state, state_next;
  logic [XW-1:0] x0, x1, cur_x;
  logic [YW-1:0] y0, y1, cur_y;
  logic [15:0]   color;
  logic          abort_q;

  logic accept, abort_seen, in_range, last_pixel, step, error_event;
  logic timer_clear, timer_enable, timer_expired;

  assign pix_write_en = (state == ST_ISSUE) || (state == ST_WAIT_ACK);
  assign done         = (state == ST_FINISH);
  assign pix_x        = cur_x;
  assign pix_y        = cur_y;
  assign pix_color    = color;

  assign timer_enable = (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE);
  assign timer_clear  = (state_next != state);

  st7735_busy_timer #(
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) u_timer (
    .clk    (system_clk),
    .rst_n  (reset_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Corners are stored sorted, so only x1/y1 need the range check and the
  // raster walk always counts upwards. An abort request arriving in the same
  // cycle it is latched is honoured immediately via abort_seen.
  always_comb begin
    state_next  = state;
    accept      = (state == ST_IDLE) && cmd_valid && cmd_ready;
    abort_seen  = abort_q || cmd_abort;
    in_range    = (x1 < XW'(WIDTH)) && (y1 < YW'(HEIGHT));
    last_pixel  = (cur_x == x1) && (cur_y == y1);
    step        = 1'b0;
    error_event = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort_seen) begin
          state_next = ST_FINISH;
        end else if (!in_range) begin
          state_next  = ST_IDLE;
          error_event = 1'b1;
        end else begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (timer_expired) begin
          state_next  = ST_IDLE;
          error_event = 1'b1;
        end else if (pix_busy) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (timer_expired) begin
          state_next  = ST_IDLE;
          error_event = 1'b1;
        end else if (!pix_busy) begin
          if (abort_seen || last_pixel) begin
            state_next = ST_FINISH;
          end else begin
            state_next = ST_ISSUE;
            step       = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command latch, raster walk and registered handshake/status outputs.
  // cmd_ready follows lcd_ready only while the FSM will be idle next cycle,
  // which drops it right after an accept.
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      x0        <= '0;
      x1        <= '0;
      y0        <= '0;
      y1        <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      color     <= '0;
      abort_q   <= 1'b0;
      cmd_ready <= 1'b0;
      error     <= 1'b0;
    end else begin
      cmd_ready <= (state_next == ST_IDLE) && lcd_ready;
      error     <= error_event;

      if (state == ST_IDLE) begin
        abort_q <= 1'b0;
      end else if (cmd_abort) begin
        abort_q <= 1'b1;
      end

      if (accept) begin
        x0    <= (cmd_x0 <= cmd_x1) ? cmd_x0 : cmd_x1;
        x1    <= (cmd_x0 <= cmd_x1) ? cmd_x1 : cmd_x0;
        y0    <= (cmd_y0 <= cmd_y1) ? cmd_y0 : cmd_y1;
        y1    <= (cmd_y0 <= cmd_y1) ? cmd_y1 : cmd_y0;
        color <= cmd_color;
      end

      if (state == ST_CHECK && state_next == ST_ISSUE) begin
        cur_x <= x0;
        cur_y <= y0;
      end else if (step) begin
        if (cur_x == x1) begin
          cur_x <= x0;
          cur_y <= cur_y + 1'b1;
        end else begin
          cur_x <= cur_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_st7735_rect_fill.sv
// tb_st7735_rect_fill
//   Directed bench for st7735_rect_fill. A driver model raises busy two cycles
//   after a write request and holds it for ten cycles. Expected pixels are
//   queued when a command is issued and popped as write requests appear.
module tb_st7735_rect_fill;
  import st7735_rect_fill_pkg::*;

  localparam int WIDTH   = 160;
  localparam int HEIGHT  = 120;
  localparam int TIMEOUT = 15;
  localparam int XW      = $clog2(WIDTH) + 1;
  localparam int YW      = $clog2(HEIGHT) + 1;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   c;
  } pix_t;

  logic          system_clk = 1'b0;
  logic          reset_n    = 1'b1;
  logic          cmd_valid  = 1'b0;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x0     = '0;
  logic [XW-1:0] cmd_x1     = '0;
  logic [YW-1:0] cmd_y0     = '0;
  logic [YW-1:0] cmd_y1     = '0;
  logic [15:0]   cmd_color  = '0;
  logic          cmd_abort  = 1'b0;
  logic          lcd_ready  = 1'b0;
  logic          pix_busy;
  logic          pix_write_en;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [15:0]   pix_color;
  logic          done;
  logic          error;

  int   checks      = 0;
  int   errors      = 0;
  int   write_count = 0;
  int   done_count  = 0;
  int   error_count = 0;
  int   wen_cycles  = 0;
  int   model_cnt   = 0;
  bit   model_en    = 1'b1;
  bit   we_prev     = 1'b0;
  pix_t exp_q[$];
  pix_t exp_pix;
  pix_t last_pix    = '0;
  pix_t cur_pix;

  assign cur_pix = {pix_x, pix_y, pix_color};

  always #5 system_clk = ~system_clk;

  st7735_rect_fill #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .BUSY_TIMEOUT(TIMEOUT)
  ) dut (
    .system_clk  (system_clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x0      (cmd_x0),
    .cmd_x1      (cmd_x1),
    .cmd_y0      (cmd_y0),
    .cmd_y1      (cmd_y1),
    .cmd_color   (cmd_color),
    .cmd_abort   (cmd_abort),
    .lcd_ready   (lcd_ready),
    .pix_busy    (pix_busy),
    .pix_write_en(pix_write_en),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .done        (done),
    .error       (error)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver model: busy two cycles after a write request, held for ten cycles.
  always @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_busy  <= 1'b0;
      model_cnt <= 0;
    end else if (pix_busy) begin
      if (model_cnt == 9) begin
        pix_busy  <= 1'b0;
        model_cnt <= 0;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end else if (pix_write_en && model_en) begin
      if (model_cnt == 1) begin
        pix_busy  <= 1'b1;
        model_cnt <= 0;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end else begin
      model_cnt <= 0;
    end
  end

  // Output monitor: scoreboard pops on each new write request and verifies
  // the pixel stays stable while the driver is busy.
  always @(negedge system_clk) begin
    if (reset_n) begin
      if (pix_write_en) wen_cycles++;
      if (done) done_count++;
      if (error) error_count++;
      if (pix_write_en && !we_prev) begin
        write_count++;
        check_output("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_pix = exp_q.pop_front();
          check_output("pixel", 64'(cur_pix), 64'(exp_pix));
        end
        last_pix = cur_pix;
      end else if (pix_busy) begin
        check_output("stable_while_busy", 64'(cur_pix), 64'(last_pix));
      end
    end
    we_prev = reset_n && pix_write_en;
  end

  task automatic push_rect(input int xa, input int ya, input int xb, input int yb,
                           input logic [15:0] c, input int limit);
    int n = 0;
    for (int y = ((ya < yb) ? ya : yb); y <= ((ya < yb) ? yb : ya); y++) begin
      for (int x = ((xa < xb) ? xa : xb); x <= ((xa < xb) ? xb : xa); x++) begin
        if (n < limit) exp_q.push_back({XW'(x), YW'(y), c});
        n++;
      end
    end
  endtask

  task automatic apply_stimulus(input int xa, input int ya, input int xb, input int yb,
                                input logic [15:0] c);
    bit ok = 1'b0;
    @(negedge system_clk);
    cmd_x0    = XW'(xa);
    cmd_x1    = XW'(xb);
    cmd_y0    = YW'(ya);
    cmd_y1    = YW'(yb);
    cmd_color = c;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge system_clk);
    end
    if (ok) begin
      @(posedge system_clk);
      #1;
    end
    cmd_valid = 1'b0;
    check_output("cmd_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_end(output bit saw_done, output bit saw_error);
    saw_done  = 1'b0;
    saw_error = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge system_clk);
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (error) begin
        saw_error = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit sd, se, hit;
    int base_w, base_d, base_e;

    // Reset and idle behaviour.
    #1 reset_n = 1'b0;
    repeat (3) @(negedge system_clk);
    check_output("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_output("rst_write_en", 64'(pix_write_en), 64'd0);
    check_output("rst_pix", 64'(cur_pix), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_error", 64'(error), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge system_clk);
    check_output("ready_waits_lcd", 64'(cmd_ready), 64'd0);
    lcd_ready = 1'b1;
    repeat (2) @(negedge system_clk);
    check_output("ready_after_lcd", 64'(cmd_ready), 64'd1);

    // 3x2 red rectangle, with accept-to-write latency checks.
    $display("[TB] rectangle (2,3)-(4,4)");
    base_d = done_count;
    base_e = error_count;
    push_rect(2, 3, 4, 4, rgb565_pack(5'h1f, 6'h00, 5'h00), 1000);
    apply_stimulus(2, 3, 4, 4, 16'hF800);
    @(negedge system_clk);
    check_output("ready_drop", 64'(cmd_ready), 64'd0);
    check_output("check_no_write", 64'(pix_write_en), 64'd0);
    @(negedge system_clk);
    check_output("first_write_latency", 64'(pix_write_en), 64'd1);
    wait_end(sd, se);
    check_output("rect1_done", 64'(sd), 64'd1);
    repeat (2) @(negedge system_clk);
    check_output("rect1_queue_empty", 64'(exp_q.size()), 64'd0);
    check_output("rect1_done_count", 64'(done_count - base_d), 64'd1);
    check_output("rect1_no_error", 64'(error_count - base_e), 64'd0);
    check_output("rect1_ready_back", 64'(cmd_ready), 64'd1);

    // Reversed X corners, lcd_ready dropped mid-fill.
    $display("[TB] reversed corners x0=5 x1=1");
    base_e = error_count;
    push_rect(1, 0, 5, 0, 16'h07E0, 1000);
    apply_stimulus(5, 0, 1, 0, 16'h07E0);
    repeat (20) @(negedge system_clk);
    lcd_ready = 1'b0;
    wait_end(sd, se);
    check_output("rev_done", 64'(sd), 64'd1);
    check_output("rev_no_error", 64'(error_count - base_e), 64'd0);
    check_output("rev_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge system_clk);
    check_output("ready_held_low", 64'(cmd_ready), 64'd0);
    lcd_ready = 1'b1;

    // Out-of-range column rejected.
    $display("[TB] out of range x1=160");
    base_w = write_count;
    apply_stimulus(0, 0, 160, 0, 16'h001F);
    @(negedge system_clk);
    check_output("range_err_early", 64'(error), 64'd0);
    @(negedge system_clk);
    check_output("range_err_pulse", 64'(error), 64'd1);
    check_output("range_ready_back", 64'(cmd_ready), 64'd1);
    @(negedge system_clk);
    check_output("range_err_single", 64'(error), 64'd0);
    check_output("range_no_writes", 64'(write_count - base_w), 64'd0);

    // Busy never rises: timeout in WAIT_ACK.
    $display("[TB] busy timeout");
    model_en = 1'b0;
    base_d = done_count;
    push_rect(7, 7, 7, 7, 16'h1234, 1000);
    apply_stimulus(7, 7, 7, 7, 16'h1234);
    wen_cycles = 0;
    wait_end(sd, se);
    check_output("timeout_error", 64'(se), 64'd1);
    check_output("timeout_wen_low", 64'(pix_write_en), 64'd0);
    check_output("timeout_wen_cycles", 64'(wen_cycles), 64'(TIMEOUT + 1));
    repeat (2) @(negedge system_clk);
    check_output("timeout_no_done", 64'(done_count - base_d), 64'd0);
    check_output("timeout_queue_empty", 64'(exp_q.size()), 64'd0);
    model_en = 1'b1;

    // Abort during third pixel busy.
    $display("[TB] abort during third pixel");
    base_w = write_count;
    base_d = done_count;
    push_rect(0, 0, 9, 9, 16'hABCD, 3);
    apply_stimulus(0, 0, 9, 9, 16'hABCD);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge system_clk);
      if (write_count - base_w == 3 && pix_busy) begin
        hit = 1'b1;
        break;
      end
    end
    check_output("abort_third_busy", 64'(hit), 64'd1);
    cmd_abort = 1'b1;
    @(negedge system_clk);
    cmd_abort = 1'b0;
    wait_end(sd, se);
    check_output("abort_done", 64'(sd), 64'd1);
    repeat (20) @(negedge system_clk);
    check_output("abort_write_count", 64'(write_count - base_w), 64'd3);
    check_output("abort_done_count", 64'(done_count - base_d), 64'd1);

    // Asynchronous reset mid-fill.
    $display("[TB] reset mid-fill");
    base_w = write_count;
    base_d = done_count;
    push_rect(0, 0, 3, 3, 16'h5555, 1000);
    apply_stimulus(0, 0, 3, 3, 16'h5555);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge system_clk);
      if (write_count - base_w == 2 && pix_busy) begin
        hit = 1'b1;
        break;
      end
    end
    check_output("reset_point", 64'(hit), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_output("arst_write_en", 64'(pix_write_en), 64'd0);
    check_output("arst_pix", 64'(cur_pix), 64'd0);
    check_output("arst_ready", 64'(cmd_ready), 64'd0);
    check_output("arst_done", 64'(done), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge system_clk);
    #3 reset_n = 1'b1;
    check_output("arst_no_done", 64'(done_count - base_d), 64'd0);

    // Single pixel after reset.
    $display("[TB] single pixel after reset");
    base_w = write_count;
    push_rect(1, 1, 1, 1, 16'h001F, 1000);
    apply_stimulus(1, 1, 1, 1, 16'h001F);
    wait_end(sd, se);
    check_output("single_done", 64'(sd), 64'd1);
    repeat (2) @(negedge system_clk);
    check_output("single_writes", 64'(write_count - base_w), 64'd1);
    check_output("single_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
